// File: rtl/alu.sv
// 8-bit ALU for the tinyCPU datapath: 16 operations, registered result E and
// condition code cc = {C, Z}, one cycle of latency.
module alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] op,
  output logic [7:0] E,
  output logic [1:0] cc
);

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpNot   = 4'd5,
    OpShl   = 4'd6,
    OpShr   = 4'd7,
    OpAsr   = 4'd8,
    OpRol   = 4'd9,
    OpRor   = 4'd10,
    OpInc   = 4'd11,
    OpDec   = 4'd12,
    OpPassA = 4'd13,
    OpPassB = 4'd14,
    OpCmp   = 4'd15
  } op_e;

  logic [7:0] e_q, e_d;
  logic [1:0] cc_q, cc_d;
  logic [8:0] sum, diff;
  logic [7:0] res;
  logic       carry;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    res   = A;
    carry = 1'b0;
    e_d   = e_q;
    unique case (op)
      OpAdd:   begin res = sum[7:0];  carry = sum[8];  end
      OpSub,
      OpCmp:   begin res = diff[7:0]; carry = diff[8]; end
      OpAnd:   res = A & B;
      OpOr:    res = A | B;
      OpXor:   res = A ^ B;
      OpNot:   res = ~A;
      OpShl:   begin res = {A[6:0], 1'b0};  carry = A[7]; end
      OpShr:   begin res = {1'b0, A[7:1]};  carry = A[0]; end
      OpAsr:   begin res = {A[7], A[7:1]};  carry = A[0]; end
      OpRol:   begin res = {A[6:0], A[7]};  carry = A[7]; end
      OpRor:   begin res = {A[0], A[7:1]};  carry = A[0]; end
      OpInc:   begin res = A + 8'd1; carry = (A == 8'hFF); end
      OpDec:   begin res = A - 8'd1; carry = (A == 8'h00); end
      OpPassA: res = A;
      OpPassB: res = B;
      // Unknown opcodes fall back to PASSA so state never picks up garbage.
      default: begin res = A; carry = 1'b0; end
    endcase
    // CMP only updates flags; E keeps its previous value.
    if (op != OpCmp) e_d = res;
    cc_d = {carry, (res == 8'h00)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q  <= 8'h00;
      cc_q <= 2'b00;
    end else begin
      e_q  <= e_d;
      cc_q <= cc_d;
    end
  end

  assign E  = e_q;
  assign cc = cc_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: reset checks, a table of directed vectors,
// and hand-written sequences for asynchronous reset mid-stream.
module tb_alu;

  logic       clk;
  logic       reset;
  logic [7:0] A, B;
  logic [3:0] op;
  logic [7:0] E;
  logic [1:0] cc;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .op    (op),
    .E     (E),
    .cc    (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e;
    logic [1:0] cc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] e_exp, input logic [1:0] cc_exp);
    checks++;
    if (E !== e_exp || cc !== cc_exp) begin
      errors++;
      $display("FAIL %s: E=%02h cc=%02b, expected E=%02h cc=%02b", name, E, cc, e_exp, cc_exp);
    end
  endtask

  task automatic add(input string n, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] e, input logic [1:0] c);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.e = e; v.cc = c;
    vecs.push_back(v);
  endtask

  initial begin
    add("add_1_2",    4'd0,  8'h01, 8'h02, 8'h03, 2'b00);
    add("add_ff_01",  4'd0,  8'hFF, 8'h01, 8'h00, 2'b11);
    add("sub_01_02",  4'd1,  8'h01, 8'h02, 8'hFF, 2'b10);
    add("sub_05_05",  4'd1,  8'h05, 8'h05, 8'h00, 2'b01);
    add("sub_00_01",  4'd1,  8'h00, 8'h01, 8'hFF, 2'b10);
    add("and_f0_0f",  4'd2,  8'hF0, 8'h0F, 8'h00, 2'b01);
    add("or_f0_0f",   4'd3,  8'hF0, 8'h0F, 8'hFF, 2'b00);
    add("xor_aa_ff",  4'd4,  8'hAA, 8'hFF, 8'h55, 2'b00);
    add("not_00",     4'd5,  8'h00, 8'h00, 8'hFF, 2'b00);
    add("shl_81",     4'd6,  8'h81, 8'h00, 8'h02, 2'b10);
    add("shr_81",     4'd7,  8'h81, 8'h00, 8'h40, 2'b10);
    add("asr_81",     4'd8,  8'h81, 8'h00, 8'hC0, 2'b10);
    add("rol_81",     4'd9,  8'h81, 8'h00, 8'h03, 2'b10);
    add("ror_81",     4'd10, 8'h81, 8'h00, 8'hC0, 2'b10);
    add("asr_40",     4'd8,  8'h40, 8'h00, 8'h20, 2'b00);
    add("shl_80",     4'd6,  8'h80, 8'h00, 8'h00, 2'b11);
    add("inc_ff",     4'd11, 8'hFF, 8'h00, 8'h00, 2'b11);
    add("inc_7f",     4'd11, 8'h7F, 8'h00, 8'h80, 2'b00);
    add("dec_00",     4'd12, 8'h00, 8'h00, 8'hFF, 2'b10);
    add("dec_01",     4'd12, 8'h01, 8'h00, 8'h00, 2'b01);
    add("passa_5a",   4'd13, 8'h5A, 8'hA5, 8'h5A, 2'b00);
    add("passb_a5",   4'd14, 8'h5A, 8'hA5, 8'hA5, 2'b00);
    add("passb_00",   4'd14, 8'h5A, 8'h00, 8'h00, 2'b01);
    add("add_10_20",  4'd0,  8'h10, 8'h20, 8'h30, 2'b00);
    add("cmp_07_07",  4'd15, 8'h07, 8'h07, 8'h30, 2'b01);
    add("cmp_03_07",  4'd15, 8'h03, 8'h07, 8'h30, 2'b10);
    add("cmp_09_07",  4'd15, 8'h09, 8'h07, 8'h30, 2'b00);
    add("passa_after_cmp", 4'd13, 8'h00, 8'h07, 8'h00, 2'b01);

    // Reset before any clock edge, then held across edges.
    reset = 1'b1; A = 8'h11; B = 8'h22; op = 4'd0;
    #1 check("reset_async", 8'h00, 2'b00);
    repeat (2) @(posedge clk);
    #1 check("reset_held", 8'h00, 2'b00);

    // Release at a negedge with the first vector on the inputs.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      op = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
      @(posedge clk);
      #1 check(vecs[i].name, vecs[i].e, vecs[i].cc);
    end

    // Reset between edges while streaming: E/cc must drop before the next edge.
    @(negedge clk);
    op = 4'd0; A = 8'h40; B = 8'h41;
    @(posedge clk);
    #1 check("stream_add", 8'h81, 2'b00);
    #2 reset = 1'b1;
    #1 check("reset_mid_stream", 8'h00, 2'b00);
    @(negedge clk);
    op = 4'd0; A = 8'h03; B = 8'h04;
    reset = 1'b0;
    @(posedge clk);
    #1 check("resume_after_reset", 8'h07, 2'b00);

    // CMP right after reset holds E at its cleared value.
    @(negedge clk);
    reset = 1'b1;
    #1 check("reset_low_clk", 8'h00, 2'b00);
    @(negedge clk);
    reset = 1'b0; op = 4'd15; A = 8'h01; B = 8'h02;
    @(posedge clk);
    #1 check("cmp_after_reset", 8'h00, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
